// File: rtl/ysyx_24120006_pkg.sv
// Shared IFU types and constants for the ysyx_24120006 NPC core.
// FSM state encoding, reset PC default and NOP encoding.
package ysyx_24120006_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_EXEC,
    S_FAULT
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24120006_ifu.sv
// Instruction fetch unit: PC register plus single-outstanding fetch FSM.
// Define YSYX_24120006_IFU_MISALIGN_CHECK_EN to fault on misaligned nextpc.
module ysyx_24120006_ifu
  import ysyx_24120006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        commit,
  input  logic [31:0] nextpc,
  output logic        fetch_fault
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        commit_ok;

`ifndef YSYX_24120006_IFU_MISALIGN_CHECK_EN
  logic unused_nextpc_lsb;
  assign unused_nextpc_lsb = ^nextpc[1:0];
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    commit_ok = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = S_FAULT;
          end else begin
            instr_d = imem_resp_data;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (out_ready) begin
          state_d   = S_EXEC;
          commit_ok = commit;
        end
      end
      S_EXEC:  commit_ok = commit;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    // Commit overrides the VALID->EXEC move and starts the next fetch.
    if (commit_ok) begin
`ifdef YSYX_24120006_IFU_MISALIGN_CHECK_EN
      if (nextpc[1:0] != 2'b00) begin
        state_d = S_FAULT;
      end else begin
        pc_d    = nextpc;
        state_d = S_REQ;
      end
`else
      pc_d    = {nextpc[31:2], 2'b00};
      state_d = S_REQ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_VALID);
  assign out_pc         = pc_q;
  assign out_instr      = instr_q;
  assign fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_ysyx_24120006_ifu.sv
// Self-checking bench for ysyx_24120006_ifu.
// Random fetch traffic against a transaction-level PC/instruction model.
module tb_ysyx_24120006_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        commit = 1'b0;
  logic [31:0] nextpc = '0;
  logic        fetch_fault;

  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  int cyc = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && imem_req_valid && imem_req_ready) hs_cnt <= hs_cnt + 1;
  end

  ysyx_24120006_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .commit(commit), .nextpc(nextpc),
    .fetch_fault(fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    out_ready       = 1'b0;
    commit          = 1'b0;
  endtask

  // Bounded wait for a request; timeout counts as a miscompare.
  task automatic wait_req();
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vecs++;
    if (imem_req_valid !== 1'b1) begin
      errs++;
      $display("FAIL wait_req: req_valid=%b required 1 within 20 cycles",
               imem_req_valid);
    end
  endtask

  // Drive REQ handshake and a 1-cycle response; leaves DUT in VALID.
  task automatic fetch_to_valid(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_pc = RST_PC;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    vecs++;
    if ({imem_req_valid, out_valid, fetch_fault} !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags: got %b required 000",
               {imem_req_valid, out_valid, fetch_fault});
    end
    vecs++;
    if (out_instr !== NOP || out_pc !== RST_PC || imem_req_addr !== RST_PC) begin
      errs++;
      $display("FAIL reset_regs: instr=%h pc=%h addr=%h required %h %h %h",
               out_instr, out_pc, imem_req_addr, NOP, RST_PC, RST_PC);
    end
    rst_n = 1'b1;
    exp_pc = RST_PC;
    step();
    vecs++;
    if (imem_req_valid !== 1'b1) begin
      errs++;
      $display("FAIL first_req: req_valid=%b required 1 one cycle after reset",
               imem_req_valid);
    end
  endtask

  task automatic test_basic();
    int c0;
    wait_req();
    vecs++;
    if (imem_req_addr !== RST_PC) begin
      errs++;
      $display("FAIL basic_addr: got %h required %h", imem_req_addr, RST_PC);
    end
    c0 = cyc;
    fetch_to_valid(NOP);
    vecs++;
    if (out_valid !== 1'b1 || cyc - c0 != 2) begin
      errs++;
      $display("FAIL basic_lat: out_valid=%b after %0d cycles required 1 after 2",
               out_valid, cyc - c0);
    end
    vecs++;
    if (out_instr !== NOP || out_pc !== RST_PC) begin
      errs++;
      $display("FAIL basic_out: instr=%h pc=%h required %h %h",
               out_instr, out_pc, NOP, RST_PC);
    end
    out_ready = 1'b1;
    commit = 1'b1;
    nextpc = 32'h8000_0004;
    step();
    idle_inputs();
    exp_pc = 32'h8000_0004;
    vecs++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
      errs++;
      $display("FAIL basic_next: valid=%b addr=%h required 1 %h",
               imem_req_valid, imem_req_addr, exp_pc);
    end
  endtask

  task automatic test_req_stall();
    int h0;
    wait_req();
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
        errs++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h required 1 %h",
                 i, imem_req_valid, imem_req_addr, exp_pc);
      end
    end
    fetch_to_valid(32'h0010_0093);
    vecs++;
    if (hs_cnt - h0 != 1 || out_instr !== 32'h0010_0093) begin
      errs++;
      $display("FAIL stall_hs: handshakes=%0d instr=%h required 1 00100093",
               hs_cnt - h0, out_instr);
    end
    out_ready = 1'b1;
    commit = 1'b1;
    nextpc = exp_pc + 4;
    step();
    idle_inputs();
    exp_pc = exp_pc + 4;
  endtask

  task automatic test_delayed_commit();
    logic [31:0] pc0;
    wait_req();
    pc0 = exp_pc;
    fetch_to_valid(32'h0020_0113);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextpc = 32'h8000_0010;
      vecs++;
      if (out_pc !== pc0 || out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL dcommit_hold%0d: pc=%h ov=%b rv=%b required %h 0 0",
                 i, out_pc, out_valid, imem_req_valid, pc0);
      end
      if (i < 2) step();
    end
    commit = 1'b1;
    step();
    commit = 1'b0;
    exp_pc = 32'h8000_0010;
    vecs++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || out_pc !== exp_pc) begin
      errs++;
      $display("FAIL dcommit_next: valid=%b addr=%h required 1 %h",
               imem_req_valid, imem_req_addr, exp_pc);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    wait_req();
    for (int k = 0; k < 4; k++) begin
      c0 = cyc;
      fetch_to_valid(32'h0000_0013 + (k << 20));
      out_ready = 1'b1;
      commit = 1'b1;
      nextpc = exp_pc + 4;
      step();
      idle_inputs();
      exp_pc = exp_pc + 4;
      vecs++;
      if (cyc - c0 != 3 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
        errs++;
        $display("FAIL b2b_%0d: cycles=%0d valid=%b addr=%h required 3 1 %h",
                 k, cyc - c0, imem_req_valid, imem_req_addr, exp_pc);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] data;
    logic [31:0] np;
    bit same;
    for (int k = 0; k < 150; k++) begin
      wait_req();
      vecs++;
      if (imem_req_addr !== exp_pc) begin
        errs++;
        $display("FAIL rnd_addr%0d: got %h required %h", k, imem_req_addr, exp_pc);
      end
      data = $urandom;
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        imem_resp_valid = 1'($urandom);
        imem_resp_err   = 1'b1;
        imem_resp_data  = $urandom;
        step();
        vecs++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
          errs++;
          $display("FAIL rnd_stall%0d: valid=%b addr=%h required 1 %h",
                   k, imem_req_valid, imem_req_addr, exp_pc);
        end
      end
      idle_inputs();
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        commit = 1'($urandom);
        out_ready = 1'($urandom);
        nextpc = $urandom;
        step();
        vecs++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          errs++;
          $display("FAIL rnd_wait%0d: ov=%b rv=%b required 0 0",
                   k, out_valid, imem_req_valid);
        end
      end
      idle_inputs();
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      step();
      imem_resp_valid = 1'b0;
      for (int w = $urandom_range(0, 2); w >= 0; w--) begin
        vecs++;
        if (out_valid !== 1'b1 || out_instr !== data || out_pc !== exp_pc) begin
          errs++;
          $display("FAIL rnd_valid%0d: ov=%b instr=%h pc=%h required 1 %h %h",
                   k, out_valid, out_instr, out_pc, data, exp_pc);
        end
        if (w > 0) begin
          commit = 1'($urandom);
          nextpc = $urandom;
          step();
        end
      end
      np = $urandom;
`ifdef YSYX_24120006_IFU_MISALIGN_CHECK_EN
      np[1:0] = 2'b00;
`endif
      same = 1'($urandom);
      out_ready = 1'b1;
      commit = same;
      nextpc = np;
      step();
      out_ready = 1'b0;
      commit = 1'b0;
      if (!same) begin
        for (int c = $urandom_range(0, 2); c > 0; c--) begin
          step();
          vecs++;
          if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || out_pc !== exp_pc) begin
            errs++;
            $display("FAIL rnd_exec%0d: ov=%b rv=%b pc=%h required 0 0 %h",
                     k, out_valid, imem_req_valid, out_pc, exp_pc);
          end
        end
        commit = 1'b1;
        step();
        commit = 1'b0;
      end
      exp_pc = {np[31:2], 2'b00};
    end
  endtask

  task automatic test_fault();
    int h0;
    wait_req();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    step();
    idle_inputs();
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({fetch_fault, out_valid, imem_req_valid} !== 3'b100) begin
        errs++;
        $display("FAIL fault_sticky%0d: {ff,ov,rv}=%b required 100",
                 i, {fetch_fault, out_valid, imem_req_valid});
      end
      imem_req_ready = 1'b1;
      imem_resp_valid = 1'($urandom);
      out_ready = 1'b1;
      commit = 1'b1;
      step();
    end
    idle_inputs();
    vecs++;
    if (hs_cnt != h0) begin
      errs++;
      $display("FAIL fault_noreq: handshakes=%0d required 0", hs_cnt - h0);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (fetch_fault !== 1'b0) begin
      errs++;
      $display("FAIL fault_clear: ff=%b required 0", fetch_fault);
    end
    step();
    rst_n = 1'b1;
    exp_pc = RST_PC;
    step();
    vecs++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errs++;
      $display("FAIL fault_refetch: valid=%b addr=%h required 1 %h",
               imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_midreset();
    wait_req();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hdead_beef;
    step();
    imem_resp_valid = 1'b0;
    vecs++;
    if (imem_req_valid !== 1'b1 || out_instr !== NOP || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL midreset: rv=%b instr=%h ov=%b required 1 %h 0",
               imem_req_valid, out_instr, out_valid, NOP);
    end
    exp_pc = RST_PC;
  endtask

  task automatic test_misalign();
    logic [31:0] pc0;
    wait_req();
    pc0 = exp_pc;
    fetch_to_valid(NOP);
    out_ready = 1'b1;
    commit = 1'b1;
    nextpc = 32'h8000_0006;
    step();
    idle_inputs();
`ifdef YSYX_24120006_IFU_MISALIGN_CHECK_EN
    vecs++;
    if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || out_pc !== pc0) begin
      errs++;
      $display("FAIL misalign_on: ff=%b rv=%b pc=%h required 1 0 %h",
               fetch_fault, imem_req_valid, out_pc, pc0);
    end
`else
    vecs++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 32'h8000_0004 || pc0 !== RST_PC) begin
      errs++;
      $display("FAIL misalign_off: ff=%b rv=%b addr=%h required 0 1 80000004",
               fetch_fault, imem_req_valid, imem_req_addr);
    end
`endif
  endtask

  initial begin
    exp_pc = RST_PC;
    test_reset();
    test_basic();
    test_req_stall();
    test_delayed_commit();
    test_back_to_back();
    test_random();
    test_fault();
    test_midreset();
    do_reset();
    step();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ysyx_24120006_ifu.md
# ysyx_24120006_ifu

Instruction fetch unit for the NPC core. It owns the architectural PC register and fetches one instruction at a time from instruction memory over a valid/ready request/response interface. It presents the instruction and its PC downstream to decode/execute. On commit it loads the PC from the next-PC computation, which is combinational logic fed by this block's `out_pc`/`out_instr`.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  fetch address; equals the PC.
- `imem_resp_valid`  in  1  fetch response valid; the memory side has no backpressure.
- `imem_resp_data`  in  32  fetched instruction.
- `imem_resp_err`  in  1  access error; qualified by `imem_resp_valid`.
- `out_valid`  out  1  instruction available downstream.
- `out_ready`  in  1  downstream accepts the instruction.
- `out_pc`  out  32  PC of the presented instruction.
- `out_instr`  out  32  presented instruction, registered.
- `commit`  in  1  the current instruction has retired and `nextpc` is valid.
- `nextpc`  in  32  next PC from the next-PC logic.
- `fetch_fault`  out  1  sticky fault flag.

## Operation
- FSM states are IDLE, REQ, WAIT, VALID, EXEC and FAULT. Only one request is outstanding at a time.
- IDLE: entered on reset. It moves to REQ unconditionally on the next cycle.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=pc. Address and valid stay stable until `imem_req_ready`. On handshake, go to WAIT.
- WAIT: wait for `imem_resp_valid`.
  - With `resp_err`=0: capture `imem_resp_data` into `out_instr` and go to VALID.
  - With `resp_err`=1: go to FAULT.
- VALID: `out_valid`=1; `out_pc`/`out_instr` are held stable until `out_ready`.
  - On handshake with `commit`=1 in the same cycle: pc<=nextpc, go to REQ.
  - On handshake without `commit`: go to EXEC.
- EXEC: wait for `commit`. On `commit`: pc<=nextpc, go to REQ.
- FAULT: terminal. `fetch_fault`=1, `out_valid`=0, `imem_req_valid`=0. Only reset exits this state.
- Inputs outside their states are ignored:
  - `imem_resp_valid` outside WAIT.
  - `commit` outside VALID-with-handshake and EXEC.
  - `out_ready` outside VALID.
- All outputs are decoded from state and registers; there is no combinational path from input to output.

## Timing
- Reset values: pc=`RESET_PC`, state=IDLE, `out_instr`=32'h0000_0013 (nop), and `imem_req_valid`=`out_valid`=`fetch_fault`=0. `out_pc` and `imem_req_addr` equal `RESET_PC`.
- The first `imem_req_valid` is asserted 1 cycle after `rst_n` deasserts.
- Best-case throughput is 3 cycles per instruction:
  - n: REQ handshake.
  - n+1: response arrives.
  - n+2: VALID handshake with commit.
  - n+3: next REQ.
- A response is accepted no earlier than the cycle after the request handshake.
- pc updates exactly on the commit edge; `out_pc` shows the new value the following cycle.
- Asserting `rst_n` low mid-transaction returns to IDLE immediately. A response arriving after reset release is ignored until the next REQ→WAIT.

## Configuration
- `YSYX_24120006_IFU_MISALIGN_CHECK_EN` defined: on commit, if `nextpc[1:0]`≠0, the pc is not updated, the FSM enters FAULT and `fetch_fault`=1 the next cycle.
- Macro undefined: pc<={nextpc[31:2],2'b00} and no fault is raised for misalignment.

## Structure
- Shared package `ysyx_24120006_pkg` holds:
  - the FSM state enum;
  - the default reset PC constant;
  - the NOP encoding 32'h0000_0013.
- No sub-module: the PC register and the FSM are small and tightly coupled, so they live inline.

## Test plan
- Reset release with `imem_req_ready`=1 and a 1-cycle response of 32'h0000_0013: `imem_req_addr`=32'h8000_0000; `out_valid` rises 2 cycles after the request handshake.
- `imem_req_ready` held low for 4 cycles: `imem_req_valid` and `imem_req_addr` stay stable throughout; exactly one request handshake occurs.
- `out_ready`=1 with `commit` delayed 3 cycles and `nextpc`=32'h8000_0010: pc does not change until the commit edge; the next request address is 32'h8000_0010.
- Same-cycle handshake with `commit` and `nextpc`=32'h8000_0004: the next REQ follows immediately; sustained rate is 3 cycles per instruction.
- Response with `imem_resp_err`=1: `fetch_fault`=1 and sticky; no further requests; `rst_n` low clears it and the next fetch is at `RESET_PC`.
- `nextpc`=32'h8000_0006 on commit:
  - macro on: FAULT and pc stays unchanged;
  - macro off: the next request address is 32'h8000_0004.
